// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, row synchronizer, press/release debounce.
// Optional auto-repeat while a key is held is enabled with `define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000,
    parameter int REPEAT_DLY   = 500000,
    parameter int REPEAT_PER   = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid
);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       pat_q, pat_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [3:0]       key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       sync1_q, rs_q;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DLY - 1);
    localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PER - 1);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_arm_q, rep_arm_d;
`endif

    // Lowest-index low row wins when several rows are pulled low together.
    function automatic logic [1:0] low_row(input logic [3:0] p);
        if (!p[0])      return 2'd0;
        else if (!p[1]) return 2'd1;
        else if (!p[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
            4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
            4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
            4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            pat_q       <= 4'hF;
            deb_q       <= '0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            sync1_q     <= 4'hF;
            rs_q        <= 4'hF;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_arm_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            pat_q       <= pat_d;
            deb_q       <= deb_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            sync1_q     <= row;
            rs_q        <= sync1_q;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_arm_q   <= rep_arm_d;
`endif
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        col_idx_d   = col_idx_q;
        pat_d       = pat_q;
        deb_d       = deb_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        case (state_q)
            SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (rs_q != 4'hF) begin
                        state_d = DEB_PRESS;
                        pat_d   = rs_q;
                        deb_d   = '0;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DEB_PRESS: begin
                if (rs_q != pat_q) begin
                    state_d   = SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    div_d     = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d     = HELD;
                    key_d       = key_code(low_row(pat_q), col_idx_q);
                    key_valid_d = 1'b1;
                    deb_d       = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            HELD: begin
                if (rs_q == 4'hF) begin
                    state_d = DEB_REL;
                    deb_d   = '0;
                end
            end
            default: begin
                if (rs_q != 4'hF) begin
                    state_d = HELD;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d   = SCAN;
                    col_idx_d = 2'd0;
                    div_d     = '0;
                    deb_d     = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
        endcase

`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d = rep_cnt_q;
        rep_arm_d = rep_arm_q;
        if (state_q == DEB_PRESS && state_d == HELD) begin
            rep_cnt_d = '0;
            rep_arm_d = 1'b0;
        end else if (state_q == HELD && state_d == HELD) begin
            // First repeat waits REPEAT_DLY, later ones REPEAT_PER.
            if (rep_cnt_q == (rep_arm_q ? PER_LAST : DLY_LAST)) begin
                key_valid_d = 1'b1;
                rep_cnt_d   = '0;
                rep_arm_d   = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_comb begin
        col       = ~(4'b0001 << col_idx_q);
        key       = key_q;
        key_valid = key_valid_q;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a column-dependent keypad model.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;

    logic [15:0] pressed;   // bit r*4+c: key at row r, column c held down

    int n_err = 0;
    int n_checks = 0;
    int cyc = 0;
    int n_strb = 0;
    int strb_cyc [16];
    int bad_col = 0;
    int bad_width = 0;
    logic kv_prev = 1'b0;

    keypad_scanner #(
        .SCAN_DIV(4), .DEBOUNCE_CNT(8), .REPEAT_DLY(40), .REPEAT_PER(10)
    ) dut (
        .clk(clk), .reset(reset), .row(row), .col(col), .key(key), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Row r reads low when a pressed key in row r sits on the driven column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            if (n_strb < 16) strb_cyc[n_strb] = cyc;
            n_strb++;
            if (kv_prev) bad_width++;
        end
        kv_prev = key_valid;
        if (!(col inside {4'hE, 4'hD, 4'hB, 4'h7})) bad_col++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the first negedge of a dwell on column pattern p.
    task automatic wait_col(input logic [3:0] p, input string tag);
        logic [3:0] prev;
        bit found;
        prev = col;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (col == p && prev != p) found = 1;
            prev = col;
        end
        if (!found) check(tag, 0, 1);
    endtask

    task automatic wait_strobe(input int target, input int max_cyc, input string tag);
        int i;
        i = 0;
        while (n_strb < target && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        if (n_strb < target) check(tag, n_strb, target);
    endtask

    initial begin
        int t0, d, t;
        logic [3:0] e;
        reset   = 1'b1;
        pressed = '0;
        #1 reset = 1'b0;
        #1;
        check("rst_col", col, 4'hE);
        check("rst_key", key, 4'h0);
        check("rst_kv", key_valid, 0);
        tick(3);
        reset = 1'b1;

        // Idle scan: four cycles per column starting at column 0.
        for (int k = 0; k < 64; k++) begin
            e = ~(4'b0001 << ((k / 4) % 4));
            check("idle_col", col, e);
            @(negedge clk);
        end
        check("idle_no_kv", n_strb, 0);

        // Key 5 (r1,c1): latency, single strobe, release resume timing.
        wait_col(4'hD, "wait_col1");
        t0 = cyc;
        pressed[5] = 1'b1;
        wait_strobe(1, 60, "kv5_timeout");
        check("kv5_key", key, 4'h5);
        check("kv5_latency_ok", int'((strb_cyc[0] - t0) <= 29), 1);
        check("kv5_latency", strb_cyc[0] - t0, 12);
        tick(5);
        check("kv5_frozen", col, 4'hD);
        pressed[5] = 1'b0;
        d = 0;
        while (col == 4'hD && d < 60) begin
            @(negedge clk);
            d++;
        end
        check("rel_delay", d, 11);
        check("rel_col0", col, 4'hE);
        tick(4);
        check("rel_col1", col, 4'hD);
        check("kv5_count", n_strb, 1);

        // Bounce on key D (r3,c3): 3 low, 2 high, then held.
        tick(20);
        wait_col(4'h7, "wait_col3");
        t0 = cyc;
        pressed[15] = 1'b1;
        tick(3);
        pressed[15] = 1'b0;
        tick(2);
        pressed[15] = 1'b1;
        wait_strobe(2, 80, "kvD_timeout");
        check("kvD_key", key, 4'hD);
        check("kvD_time", strb_cyc[1] - t0, 30);
        tick(10);
        pressed[15] = 1'b0;
        tick(30);
        check("kvD_count", n_strb, 2);

        // Isolated 5-cycle glitch is rejected.
        wait_col(4'h7, "wait_col3b");
        pressed[15] = 1'b1;
        tick(5);
        pressed[15] = 1'b0;
        tick(40);
        check("glitch_count", n_strb, 2);
        check("glitch_key", key, 4'hD);

        // Rows r1 and r3 on column 0: r1 wins; release bounce yields no new strobe.
        pressed[4]  = 1'b1;
        pressed[12] = 1'b1;
        wait_strobe(3, 60, "kv4_timeout");
        check("kv4_key", key, 4'h4);
        tick(5);
        pressed = '0;
        tick(4);
        pressed[0] = 1'b1;
        tick(2);
        pressed[0] = 1'b0;
        tick(40);
        check("relbounce_count", n_strb, 3);
        check("relbounce_key", key, 4'h4);

        // Key 9 (r2,c2) held 75 cycles after acceptance.
        pressed[10] = 1'b1;
        wait_strobe(4, 60, "kv9_timeout");
        t = strb_cyc[3];
        check("kv9_key", key, 4'h9);
        while (cyc < t + 75) @(negedge clk);
        pressed[10] = 1'b0;
        tick(40);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("rep_count", n_strb, 8);
        check("rep_1", strb_cyc[4] - t, 40);
        check("rep_2", strb_cyc[5] - t, 50);
        check("rep_3", strb_cyc[6] - t, 60);
        check("rep_4", strb_cyc[7] - t, 70);
`else
        check("norep_count", n_strb, 4);
`endif
        check("rep_key", key, 4'h9);

        // Reset during press debounce aborts the press.
        d = n_strb;
        wait_col(4'hD, "wait_col1b");
        pressed[5] = 1'b1;
        tick(6);
        reset = 1'b0;
        #1;
        check("mid_rst_col", col, 4'hE);
        check("mid_rst_key", key, 4'h0);
        check("mid_rst_kv", key_valid, 0);
        pressed = '0;
        tick(3);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("post_rst_col", col, (k < 4) ? 4'hE : 4'hD);
            @(negedge clk);
        end
        tick(40);
        check("post_rst_count", n_strb, d);
        check("post_rst_key", key, 4'h0);

        check("col_onehot", bad_col, 0);
        check("kv_width", bad_width, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
